// File: rtl/fps_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fps_meter_pkg
// Description : Shared definitions for the FPS meter and the text overlay
//               that indexes its glyph table by BCD nibble.
// Revision    : 1.0 - initial release
// ============================================================================
package fps_meter_pkg;

  localparam int BCD_DIGITS = 3;
  localparam int BIN_W      = 10;
  localparam int CONV_ITERS = 10;

  // Converter sequencing: wait for a start, shift BIN_W times, publish.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Clamp a raw frame count to the largest value the readout can show.
  function automatic logic [BIN_W-1:0] sat_count(input logic [BIN_W-1:0] cnt,
                                                 input logic [BIN_W-1:0] limit);
    return (cnt > limit) ? limit : cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fps_meter_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd
// Description : Sequential shift-add (double-dabble) binary to BCD converter.
//               One bit per cycle; the BCD result is stable while done is high.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd #(
  parameter int BIN_W      = fps_meter_pkg::BIN_W,
  parameter int BCD_DIGITS = fps_meter_pkg::BCD_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BIN_W-1:0]        bin_out,
  output logic [4*BCD_DIGITS-1:0] bcd_out
);
  import fps_meter_pkg::*;

  localparam int c_bcd_w = 4 * BCD_DIGITS;
  localparam int c_w     = c_bcd_w + BIN_W;
  localparam int c_iters = BIN_W;
  localparam int c_iw    = $clog2(c_iters + 1);

  conv_state_t      r_state;
  logic [c_w-1:0]   r_shift;
  logic [c_w-1:0]   w_adj;
  logic [c_iw-1:0]  r_iter;
  logic [BIN_W-1:0] r_bin;

  // Add 3 to every BCD nibble that would overflow past 9 after the next shift.
  always_comb begin
    w_adj = r_shift;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (r_shift[BIN_W + 4*d +: 4] >= 4'd5) begin
        w_adj[BIN_W + 4*d +: 4] = r_shift[BIN_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  // Conversion sequencer; busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_iter  <= '0;
      r_bin   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= {{c_bcd_w{1'b0}}, bin_in};
            r_bin   <= bin_in;
            r_iter  <= '0;
            r_state <= SHIFT;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          r_shift <= {w_adj[c_w-2:0], 1'b0};
          r_iter  <= r_iter + 1'b1;
          if (r_iter == c_iw'(c_iters - 1)) begin
            r_state <= DONE;
            done    <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bin_out = r_bin;
  assign bcd_out = r_shift[c_w-1 -: c_bcd_w];

endmodule
`default_nettype wire

// File: rtl/fps_meter.sv
`default_nettype none
// ============================================================================
// Module      : fps_meter
// Description : Counts frame-sync rising edges over a one-second gate and
//               publishes the count in binary and as three BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
module fps_meter
  import fps_meter_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int MAX_FPS  = 999
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic                    vsync_in,
  output logic [BIN_W-1:0]        fps_bin,
  output logic [4*BCD_DIGITS-1:0] fps_digits,
  output logic                    fps_valid,
  output logic                    busy
);

  localparam int               c_gate_w    = $clog2(CLK_FREQ);
  localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(CLK_FREQ - 1);
  localparam logic [BIN_W-1:0] c_max_fps   = BIN_W'(MAX_FPS);
  localparam logic [BIN_W-1:0] c_frame_max = {BIN_W{1'b1}};

  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_sync3;
  logic                    r_edge;
  logic [c_gate_w-1:0]     r_gate_cnt;
  logic                    w_gate_tick;
  logic [BIN_W-1:0]        r_frame_cnt;
  logic [BIN_W-1:0]        w_sat_cnt;
  logic                    w_conv_busy;
  logic                    w_conv_done;
  logic [BIN_W-1:0]        w_conv_bin;
  logic [4*BCD_DIGITS-1:0] w_conv_bcd;

  // Two-flop synchroniser on vsync, then a registered rising-edge pulse.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= vsync_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_edge  <= r_sync2 & ~r_sync3;
    end
  end

  assign w_gate_tick = (r_gate_cnt == c_gate_last);

  // Free-running gate timer, one tick per CLK_FREQ cycles.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_gate_cnt <= '0;
    end else if (w_gate_tick) begin
      r_gate_cnt <= '0;
    end else begin
      r_gate_cnt <= r_gate_cnt + 1'b1;
    end
  end

  // Saturating frame counter; an edge coincident with the tick opens the new window.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_gate_tick) begin
      r_frame_cnt <= {{(BIN_W-1){1'b0}}, r_edge};
    end else if (r_edge && (r_frame_cnt != c_frame_max)) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign w_sat_cnt = sat_count(r_frame_cnt, c_max_fps);

  bin2bcd #(
    .BIN_W      (BIN_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .clk     (pixel_clk),
    .rst     (rst),
    .start   (w_gate_tick),
    .bin_in  (w_sat_cnt),
    .busy    (w_conv_busy),
    .done    (w_conv_done),
    .bin_out (w_conv_bin),
    .bcd_out (w_conv_bcd)
  );

  // Publish a finished conversion in one step so the overlay never sees partial digits.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      fps_bin    <= '0;
      fps_digits <= '0;
      fps_valid  <= 1'b0;
    end else begin
      fps_valid <= w_conv_done;
      if (w_conv_done) begin
        fps_bin    <= w_conv_bin;
        fps_digits <= w_conv_bcd;
      end
    end
  end

  assign busy = w_conv_busy;

endmodule
`default_nettype wire

// File: tb/tb_fps_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fps_meter
// Description : Self-checking bench for fps_meter. Two instances share clock
//               and reset: A (100-cycle gate) with scripted/random vsync, and
//               B (2100-cycle gate) driven with a toggle-every-cycle vsync.
//               Expected reports come from counting rising edges of the
//               recorded vsync samples that fall inside each gate window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fps_meter;

  localparam int FA = 100;
  localparam int FB = 2100;
  localparam int NS = 8192;

  logic        pixel_clk = 1'b0;
  logic        rst       = 1'b1;
  logic        vs_a      = 1'b0;
  logic        vs_b      = 1'b0;
  logic [9:0]  bin_a, bin_b;
  logic [11:0] dig_a, dig_b;
  logic        val_a, val_b, busy_a, busy_b;

  bit samp [2][NS];
  int checks = 0;
  int errors = 0;
  int first_val;

  always #5 pixel_clk = ~pixel_clk;

  fps_meter #(.CLK_FREQ(FA), .MAX_FPS(999)) dut_a (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .vsync_in   (vs_a),
    .fps_bin    (bin_a),
    .fps_digits (dig_a),
    .fps_valid  (val_a),
    .busy       (busy_a)
  );

  fps_meter #(.CLK_FREQ(FB), .MAX_FPS(999)) dut_b (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .vsync_in   (vs_b),
    .fps_bin    (bin_b),
    .fps_digits (dig_b),
    .fps_valid  (val_b),
    .busy       (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // A rising edge is a high sample preceded by a low one (reset leaves the synchroniser low).
  function automatic bit rising(input int d, input int s);
    bit prev;
    prev = (s == 0) ? 1'b0 : samp[d][s-1];
    return samp[d][s] && !prev;
  endfunction

  // The window closed by the tick at cycle t owns edges sampled in [t-f-3, t-4].
  function automatic int exp_count(input int d, input int t, input int f);
    int n;
    n = 0;
    for (int s = t - f - 3; s <= t - 4; s++)
      if (s >= 0 && rising(d, s)) n++;
    return (n > 999) ? 999 : n;
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Scripted vsync for A: steady 10/window, silence, boundary case, then random.
  function automatic bit pat_a(input int s);
    if (s < 300) return (s % 10) == 0;
    if (s < 500) return 1'b0;
    if (s < 600) return (s == 510) || (s == 530) || (s == 550) || (s == 570) || (s == 596);
    if (s < 700) return 1'b0;
    return $urandom_range(0, 3) == 0;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_bin_a"},  bin_a,  0);
    check({tag, "_dig_a"},  dig_a,  0);
    check({tag, "_val_a"},  val_a,  0);
    check({tag, "_busy_a"}, busy_a, 0);
    check({tag, "_bin_b"},  bin_b,  0);
    check({tag, "_dig_b"},  dig_b,  0);
    check({tag, "_val_b"},  val_b,  0);
    check({tag, "_busy_b"}, busy_b, 0);
  endtask

  // Compare one instance's outputs at observation cycle c (state after edge c-1).
  task automatic observe(input int d, input int c, input bit scripted);
    int          f, t, n, w;
    bit          ev;
    logic        val, bsy;
    logic [9:0]  bin;
    logic [11:0] dig;
    string       p;
    f   = d ? FB : FA;
    val = d ? val_b : val_a;
    bsy = d ? busy_b : busy_a;
    bin = d ? bin_b : bin_a;
    dig = d ? dig_b : dig_a;
    p   = d ? "b" : "a";
    ev  = (c >= 12) && (((c - 12) % f) == f - 1);
    if (ev || val) check({p, "_valid"}, val, ev);
    if (ev) begin
      t = c - 12;
      n = exp_count(d, t, f);
      check({p, "_bin"}, bin, n);
      check({p, "_digits"}, dig, to_bcd(n));
      check({p, "_busy_done"}, bsy, 0);
      if (scripted) begin
        w = t / f;
        if (d == 1) begin
          check("sat_bin", bin, 999);
          check("sat_digits", dig, 12'h999);
        end else if (w <= 2) begin
          check("steady_bin", bin, 10);
          check("steady_digits", dig, 12'h010);
        end else if (w <= 4) begin
          check("none_bin", bin, 0);
          check("none_digits", dig, 12'h000);
        end else if (w == 5) begin
          check("boundary_close", bin, 4);
        end else if (w == 6) begin
          check("boundary_next", bin, 1);
        end
      end
    end
    if (c >= 1 && ((c - 1) % f) == f - 1) check({p, "_busy_start"}, bsy, 1);
    if (d == 0 && val && first_val < 0) begin
      first_val = c;
      // c counts observation points; the release cycle itself is cycle 1.
      if (scripted) check("first_valid_cycle", c + 1, 112);
    end
  endtask

  task automatic run_seg(input int ncyc, input int abort_at, input bit scripted);
    rst = 1'b1;
    vs_a = 1'b0;
    vs_b = 1'b0;
    repeat (5) @(negedge pixel_clk);
    check_zero("reset");
    first_val = -1;
    rst = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) @(negedge pixel_clk);
      observe(0, c, scripted);
      observe(1, c, scripted);
      if (c == abort_at) begin
        check("abort_busy_before", busy_a, 1);
        rst = 1'b1;
        @(negedge pixel_clk);
        check_zero("abort");
        for (int k = 0; k < 20; k++) begin
          @(negedge pixel_clk);
          if (val_a) check("abort_no_valid", val_a, 0);
        end
        return;
      end
      samp[0][c] = scripted ? pat_a(c) : bit'($urandom_range(0, 3) == 0);
      samp[1][c] = scripted ? bit'(c % 2) : bit'($urandom_range(0, 1));
      vs_a = samp[0][c];
      vs_b = samp[1][c];
    end
  endtask

  initial begin
    run_seg(2300, -1, 1'b1);
    run_seg(400, FA - 1 + 5, 1'b0);
    run_seg(450, -1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
